ssfr_readback: RTL and testbench

//  Read-back path for the 16-bit SSFR configuration word: on request, snapshots
//  the live word and streams it out MSB-byte-first over an 8-bit valid/ready

---
 rtl/ssfr_readback.sv | 123 ++++++++++++
 tb/tb_ssfr_readback.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssfr_readback.sv
// SSFR read-back: snapshots the live configuration word on request and streams it MSB byte first.
// Latency: first byte valid the cycle after the request edge; NBYTES cycles minimum with READY held high.
// Backpressure: holds DOUT/DOUT_VALID until READY; aborts with a TIMEOUT pulse after TIMEOUT_CYC stalled cycles (0 = never).
module ssfr_readback #(
  parameter int                    NBYTES      = 2,
  parameter int                    TIMEOUT_CYC = 256,
  parameter logic [8*NBYTES-1:0]   SNAP_RST    = (8*NBYTES)'(16'h2280)
) (
  input  logic                  i_clkext,
  input  logic                  i_rst_n,
  input  logic [8*NBYTES-1:0]   i_ssfr_in,
  input  logic                  i_rd_req,
  output logic [7:0]            o_dout,
  output logic                  o_dout_valid,
  input  logic                  i_dout_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_drop,
  output logic                  o_timeout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_snap, w_snap_nxt;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [7:0]    r_dout, w_dout_nxt;
  logic          r_done, w_done_nxt;
  logic          r_drop, w_drop_nxt;
  logic          r_tmo, w_tmo_nxt;

  // Byte k of the word, counted from the most significant byte.
  function automatic logic [7:0] byte_at(input logic [W-1:0] w, input logic [IW-1:0] k);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < NBYTES; j++) begin
      if (int'(k) == j) b = w[W-1-8*j -: 8];
    end
    return b;
  endfunction

  // State and datapath registers; pulses are registered so they appear the cycle after the event.
  always_ff @(posedge i_clkext or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_snap  <= SNAP_RST;
      r_idx   <= '0;
      r_timer <= '0;
      r_dout  <= 8'h00;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_snap  <= w_snap_nxt;
      r_idx   <= w_idx_nxt;
      r_timer <= w_timer_nxt;
      r_dout  <= w_dout_nxt;
      r_done  <= w_done_nxt;
      r_drop  <= w_drop_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Next-state logic: request capture, beat hand-off, stall timer and abort.
  always_comb begin
    w_state_nxt = r_state;
    w_snap_nxt  = r_snap;
    w_idx_nxt   = r_idx;
    w_timer_nxt = r_timer;
    w_dout_nxt  = r_dout;
    w_done_nxt  = 1'b0;
    w_drop_nxt  = 1'b0;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_rd_req) begin
          // Freeze the live word so mid-transfer config writes cannot tear the read-back.
          w_state_nxt = S_SEND;
          w_snap_nxt  = i_ssfr_in;
          w_idx_nxt   = '0;
          w_timer_nxt = '0;
          w_dout_nxt  = i_ssfr_in[W-1 -: 8];
        end
      end
      S_SEND: begin
        if (i_rd_req) w_drop_nxt = 1'b1;
        if (i_dout_ready) begin
          // A beat accepted on the timeout edge still counts: READY wins.
          w_timer_nxt = '0;
          if (r_idx == LAST) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt  = r_idx + 1'b1;
            w_dout_nxt = byte_at(r_snap, r_idx + 1'b1);
          end
        end else if ((TIMEOUT_CYC > 0) && (r_timer == TMAX)) begin
          w_state_nxt = S_IDLE;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = (r_state == S_SEND);
  assign o_busy       = (r_state == S_SEND);
  assign o_done       = r_done;
  assign o_rd_drop    = r_drop;
  assign o_timeout    = r_tmo;

endmodule

// File: tb/tb_ssfr_readback.sv
// Bench for ssfr_readback: three instances (timeout 256, 4, disabled) share stimulus.
// Directed table and hand sequences, then random traffic against a per-instance transaction model.
module tb_ssfr_readback;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        rdy;
  logic [15:0] ssfr;
  logic [7:0]  dout_w [3];
  logic [2:0]  vld_w, busy_w, done_w, drop_w, tmo_w;

  ssfr_readback #(.NBYTES(2), .TIMEOUT_CYC(256), .SNAP_RST(16'h2280)) u_dut (
    .i_clkext(clk), .i_rst_n(rst_n), .i_ssfr_in(ssfr), .i_rd_req(req),
    .o_dout(dout_w[0]), .o_dout_valid(vld_w[0]), .i_dout_ready(rdy),
    .o_busy(busy_w[0]), .o_done(done_w[0]), .o_rd_drop(drop_w[0]), .o_timeout(tmo_w[0]));

  ssfr_readback #(.NBYTES(2), .TIMEOUT_CYC(4), .SNAP_RST(16'h2280)) u_dut4 (
    .i_clkext(clk), .i_rst_n(rst_n), .i_ssfr_in(ssfr), .i_rd_req(req),
    .o_dout(dout_w[1]), .o_dout_valid(vld_w[1]), .i_dout_ready(rdy),
    .o_busy(busy_w[1]), .o_done(done_w[1]), .o_rd_drop(drop_w[1]), .o_timeout(tmo_w[1]));

  ssfr_readback #(.NBYTES(2), .TIMEOUT_CYC(0), .SNAP_RST(16'h2280)) u_dut0 (
    .i_clkext(clk), .i_rst_n(rst_n), .i_ssfr_in(ssfr), .i_rd_req(req),
    .o_dout(dout_w[2]), .o_dout_valid(vld_w[2]), .i_dout_ready(rdy),
    .o_busy(busy_w[2]), .o_done(done_w[2]), .o_rd_drop(drop_w[2]), .o_timeout(tmo_w[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transaction-level model: word, bytes still to send, consecutive stalled cycles.
  typedef struct {
    logic [15:0] word;
    int          rem;
    int          stall;
    logic [7:0]  dout;
    logic        done;
    logic        drop;
    logic        tmo;
  } mdl_t;

  typedef struct {
    logic        req;
    logic        rdy;
    logic [15:0] ssfr;
    logic [7:0]  dout;
    logic        valid;
    logic        done;
    logic        drop;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  mdl_t m [3];
  int   tmo_p [3] = '{256, 4, 0};
  vec_t tbl [23];

  function automatic mdl_t mdl_rst();
    mdl_t r;
    r.word = 16'h2280; r.rem = 0; r.stall = 0; r.dout = 8'h00;
    r.done = 1'b0; r.drop = 1'b0; r.tmo = 1'b0;
    return r;
  endfunction

  // Byte that is sent when 'rem' bytes are still outstanding (rem=2 -> high byte).
  function automatic logic [7:0] byte_of(logic [15:0] w, int rem);
    logic [15:0] t;
    t = w >> (8 * (rem - 1));
    return t[7:0];
  endfunction

  function automatic mdl_t step(mdl_t cur, logic rq, logic rd, logic [15:0] sf, int tmo);
    mdl_t n;
    n = cur;
    n.done = 1'b0; n.drop = 1'b0; n.tmo = 1'b0;
    if (cur.rem > 0) begin
      if (rq) n.drop = 1'b1;
      if (rd) begin
        n.rem   = cur.rem - 1;
        n.stall = 0;
        if (n.rem == 0) n.done = 1'b1;
        else            n.dout = byte_of(cur.word, n.rem);
      end else begin
        n.stall = cur.stall + 1;
        if (tmo > 0 && n.stall == tmo) begin
          n.rem = 0;
          n.tmo = 1'b1;
        end
      end
    end else if (rq) begin
      n.word  = sf;
      n.rem   = 2;
      n.stall = 0;
      n.dout  = byte_of(sf, 2);
    end
    return n;
  endfunction

  function automatic logic [12:0] obs(int k);
    return {dout_w[k], vld_w[k], busy_w[k], done_w[k], drop_w[k], tmo_w[k]};
  endfunction

  function automatic logic [12:0] exp_of(mdl_t x);
    logic v;
    v = (x.rem > 0);
    return {x.dout, v, v, x.done, x.drop, x.tmo};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: advance the models with the inputs present at the edge, sample 1 ns after it.
  task automatic cyc();
    mdl_t nx [3];
    for (int k = 0; k < 3; k++) nx[k] = step(m[k], req, rdy, ssfr, tmo_p[k]);
    @(posedge clk);
    #1;
    m = nx;
  endtask

  // Called 1 ns after an edge; asserts reset across one edge and releases mid-cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    rdy   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) m[k] = mdl_rst();
  endtask

  initial begin
    int first_t [3];
    int hold_bad;
    int tmo0_cnt;
    int stuck_left;

    tbl[0]  = '{1'b1, 1'b1, 16'h2280, 8'h22, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'h2280, 8'h80, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h2280, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'h2280, 8'h80, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'hA55A, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'h1234, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 16'h1234, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 16'h1234, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 16'h1234, 8'h5A, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 16'h1234, 8'h5A, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 16'h1234, 8'h12, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 16'h1234, 8'h34, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 16'h1234, 8'h34, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 16'hBEEF, 8'hBE, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 16'hBEEF, 8'hBE, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 16'hBEEF, 8'hEF, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 16'hBEEF, 8'hEF, 1'b0, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 16'hC33C, 8'hC3, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 16'hC33C, 8'h3C, 1'b1, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 1'b1, 16'hC33C, 8'h3C, 1'b0, 1'b1, 1'b1};
    tbl[20] = '{1'b1, 1'b1, 16'hC33C, 8'hC3, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 1'b1, 16'hC33C, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b1, 16'hC33C, 8'h3C, 1'b0, 1'b1, 1'b0};

    // Reset state of every instance.
    rst_n = 1'b1; req = 1'b0; rdy = 1'b0; ssfr = 16'h2280;
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) chk($sformatf("reset_outs_dut%0d", k), 32'(obs(k)), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) m[k] = mdl_rst();

    // Directed table: basic read, stall with snapshot freeze, drops, back-to-back.
    for (int i = 0; i < 23; i++) begin
      req = tbl[i].req; rdy = tbl[i].rdy; ssfr = tbl[i].ssfr;
      cyc();
      chk($sformatf("tbl_row%0d", i),
          32'({dout_w[0], vld_w[0], busy_w[0], done_w[0], drop_w[0], tmo_w[0]}),
          32'({tbl[i].dout, tbl[i].valid, tbl[i].valid, tbl[i].done, tbl[i].drop, 1'b0}));
    end

    // Stall timeout on the 4-cycle instance, then a normal read afterwards.
    do_reset();
    ssfr = 16'h6789; req = 1'b1; rdy = 1'b0;
    cyc();
    req = 1'b0;
    chk("tmo4_valid_c1", 32'({vld_w[1], tmo_w[1]}), 32'b10);
    for (int i = 2; i <= 4; i++) begin
      cyc();
      chk($sformatf("tmo4_valid_c%0d", i), 32'({vld_w[1], tmo_w[1], dout_w[1]}), 32'({2'b10, 8'h67}));
    end
    cyc();
    chk("tmo4_abort", 32'({vld_w[1], busy_w[1], done_w[1], tmo_w[1]}), 32'b0001);
    cyc();
    chk("tmo4_pulse_end", 32'(tmo_w[1]), 32'd0);
    ssfr = 16'h4321; req = 1'b1; rdy = 1'b1;
    cyc();
    req = 1'b0;
    chk("tmo4_after_b0", 32'({vld_w[1], dout_w[1]}), 32'({1'b1, 8'h43}));
    cyc();
    chk("tmo4_after_b1", 32'({vld_w[1], dout_w[1]}), 32'({1'b1, 8'h21}));
    cyc();
    chk("tmo4_after_done", 32'({vld_w[1], done_w[1], tmo_w[1]}), 32'b010);

    // Asynchronous reset after the first beat is accepted.
    do_reset();
    ssfr = 16'h1234; req = 1'b1; rdy = 1'b1;
    cyc();
    req = 1'b0;
    cyc();
    chk("arst_pre", 32'({vld_w[0], dout_w[0]}), 32'({1'b1, 8'h34}));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", 32'(obs(0)), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) m[k] = mdl_rst();
    cyc();
    chk("arst_no_done", 32'({vld_w[0], done_w[0], tmo_w[0]}), 32'd0);
    ssfr = 16'hFFFF; req = 1'b1;
    cyc();
    req = 1'b0;
    chk("arst_rd_b0", 32'({vld_w[0], dout_w[0]}), 32'({1'b1, 8'hFF}));
    cyc();
    chk("arst_rd_b1", 32'({vld_w[0], dout_w[0]}), 32'({1'b1, 8'hFF}));
    cyc();
    chk("arst_rd_done", 32'({vld_w[0], done_w[0]}), 32'b01);

    // Long stall: the disabled-timeout instance holds; the others abort at their limits.
    do_reset();
    ssfr = 16'h5AA5; req = 1'b1; rdy = 1'b0;
    cyc();
    req = 1'b0;
    first_t = '{-1, -1, -1};
    hold_bad = 0;
    tmo0_cnt = 0;
    for (int i = 1; i <= 1000; i++) begin
      cyc();
      for (int k = 0; k < 3; k++) if (tmo_w[k] && first_t[k] < 0) first_t[k] = i;
      if (!vld_w[2] || dout_w[2] !== 8'h5A) hold_bad++;
      if (tmo_w[2]) tmo0_cnt++;
    end
    chk("stall_tmo256_at", 32'(first_t[0]), 32'd256);
    chk("stall_tmo4_at", 32'(first_t[1]), 32'd4);
    chk("stall_tmo0_pulses", 32'(tmo0_cnt), 32'd0);
    chk("stall_tmo0_hold_bad", 32'(hold_bad), 32'd0);
    rdy = 1'b1;
    cyc();
    chk("stall_tmo0_b1", 32'({vld_w[2], dout_w[2]}), 32'({1'b1, 8'hA5}));
    cyc();
    chk("stall_tmo0_done", 32'({vld_w[2], done_w[2]}), 32'b01);

    // Random traffic against the model, all three instances.
    do_reset();
    stuck_left = 0;
    for (int c = 0; c < 4000; c++) begin
      req  = ($urandom_range(0, 3) == 0);
      ssfr = 16'($urandom);
      if (stuck_left > 0) begin
        rdy = 1'b0;
        stuck_left--;
      end else begin
        if ($urandom_range(0, 99) == 0) stuck_left = $urandom_range(3, 300);
        rdy = ($urandom_range(0, 2) != 0);
      end
      cyc();
      for (int k = 0; k < 3; k++)
        chk($sformatf("rand_dut%0d_c%0d", k, c), 32'(obs(k)), 32'(exp_of(m[k])));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
